// File: rtl/ddr_cmd_pkg.sv
// Shared command codes and FSM state encoding for the DDR3 command engine.
package ddr_cmd_pkg;

    localparam logic [3:0] CMD_RD = 4'b0011;
    localparam logic [3:0] CMD_WR = 4'b0100;

    typedef enum logic [2:0] {
        ST_INIT_DLY,
        ST_INIT_REQ,
        ST_IDLE,
        ST_ISSUE,
        ST_WR_DATA
    } state_t;

    function automatic logic cmd_legal(input logic [3:0] c);
        return (c == CMD_RD) || (c == CMD_WR);
    endfunction

endpackage

// File: rtl/ddr_rd_tracker.sv
// Tracks reads accepted by the MC but not yet returned; optional watchdog
// enabled by the DDR_RD_TIMEOUT_EN macro.
module ddr_rd_tracker #(
    parameter int MAX_RD_OUT = 4,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic clk_133M,
    input  logic rst_133M,
    input  logic rd_issue,
    input  logic rd_return,
    output logic full,
    output logic ret_accept,
    output logic underflow,
    output logic wd_fire,
    output logic rd_timeout
);

    if (MAX_RD_OUT < 2 || MAX_RD_OUT > 15 || RD_TIMEOUT < 2) begin : g_param_check
        $error("ddr_rd_tracker: parameter out of range");
    end

    logic [3:0] out_cnt;
    logic       dec;

    // A return landing in the same cycle as a read accept pairs with it.
    assign ret_accept = rd_return & ((out_cnt != 4'd0) | rd_issue);
    assign underflow  = rd_return & (out_cnt == 4'd0) & ~rd_issue;
    assign full       = (out_cnt == 4'(MAX_RD_OUT));
    assign dec        = ret_accept | wd_fire;

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            out_cnt <= 4'd0;
        end else begin
            case ({rd_issue, dec})
                2'b10:   out_cnt <= out_cnt + 4'd1;
                2'b01:   out_cnt <= out_cnt - 4'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

`ifdef DDR_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(RD_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Synthesised zero-data return keeps the upstream FIFO aligned with issues.
    assign wd_fire = (out_cnt != 4'd0) & ~rd_return & (wd_cnt == WD_W'(RD_TIMEOUT - 1));

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            wd_cnt     <= '0;
            rd_timeout <= 1'b0;
        end else begin
            if (out_cnt == 4'd0 || rd_return || wd_fire)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire)
                rd_timeout <= 1'b1;
        end
    end
`else
    assign wd_fire    = 1'b0;
    assign rd_timeout = 1'b0;
`endif

endmodule

// File: rtl/ddr_cmd_engine.sv
// Executes read/write commands against the DDR3 MC native port and sequences
// MC initialisation. Optional read watchdog: DDR_RD_TIMEOUT_EN.
module ddr_cmd_engine
    import ddr_cmd_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 128,
    parameter int MAX_RD_OUT = 4,
    parameter int INIT_DLY   = 16,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic              clk_133M,
    input  logic              rst_133M,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    input  logic [ADDR_W-1:0] ddr_address,
    input  logic [DATA_W-1:0] ddr_wr_data,
    output logic              cmd_busy,
    output logic [DATA_W-1:0] ddr_rd_data,
    output logic              ddr_data_valid,
    output logic              init_done,
    output logic              cmd_err,
    output logic              mc_init_start,
    input  logic              mc_init_done,
    output logic [3:0]        mc_cmd,
    output logic              mc_cmd_valid,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic              mc_cmd_rdy,
    input  logic              mc_datain_rdy,
    output logic [DATA_W-1:0] mc_write_data,
    input  logic [DATA_W-1:0] mc_read_data,
    input  logic              mc_read_data_valid,
    output logic              rd_timeout
);

    localparam int DLY_W = $clog2(INIT_DLY + 1);

    state_t           state;
    logic [DLY_W-1:0] dly_cnt;
    logic             rd_issue;
    logic             rd_full;
    logic             ret_accept;
    logic             underflow;
    logic             wd_fire;
    logic             accept;
    logic             err_set;

    assign cmd_busy = (state != ST_IDLE) | rd_full | ~init_done;
    assign accept   = cmd_valid & ~cmd_busy & cmd_legal(cmd);
    assign err_set  = (cmd_valid & (cmd_busy | ~cmd_legal(cmd))) | underflow;
    assign rd_issue = (state == ST_ISSUE) & mc_cmd_rdy & (mc_cmd == CMD_RD);

    ddr_rd_tracker #(
        .MAX_RD_OUT(MAX_RD_OUT),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) u_rd_tracker (
        .clk_133M  (clk_133M),
        .rst_133M  (rst_133M),
        .rd_issue  (rd_issue),
        .rd_return (mc_read_data_valid),
        .full      (rd_full),
        .ret_accept(ret_accept),
        .underflow (underflow),
        .wd_fire   (wd_fire),
        .rd_timeout(rd_timeout)
    );

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            state          <= ST_INIT_DLY;
            dly_cnt        <= '0;
            mc_init_start  <= 1'b0;
            init_done      <= 1'b0;
            mc_cmd_valid   <= 1'b0;
            mc_cmd         <= 4'd0;
            mc_addr        <= '0;
            mc_write_data  <= '0;
            cmd_err        <= 1'b0;
            ddr_data_valid <= 1'b0;
            ddr_rd_data    <= '0;
        end else begin
            ddr_data_valid <= ret_accept | wd_fire;
            if (ret_accept)
                ddr_rd_data <= mc_read_data;
            else if (wd_fire)
                ddr_rd_data <= '0;
            if (err_set)
                cmd_err <= 1'b1;

            case (state)
                ST_INIT_DLY: begin
                    if (dly_cnt == DLY_W'(INIT_DLY - 1)) begin
                        mc_init_start <= 1'b1;
                        state         <= ST_INIT_REQ;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ST_INIT_REQ: begin
                    if (mc_init_done) begin
                        mc_init_start <= 1'b0;
                        init_done     <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        mc_cmd        <= cmd;
                        mc_addr       <= ddr_address;
                        mc_write_data <= ddr_wr_data;
                        mc_cmd_valid  <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mc_cmd_rdy) begin
                        mc_cmd_valid <= 1'b0;
                        state        <= (mc_cmd == CMD_RD) ? ST_IDLE : ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (mc_datain_rdy)
                        state <= ST_IDLE;
                end
                default: state <= ST_INIT_DLY;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_cmd_engine.sv
// Directed bench for ddr_cmd_engine: table-driven command vectors plus
// hand sequences for init, read back-pressure, errors and mid-write reset.
module tb_ddr_cmd_engine;
    import ddr_cmd_pkg::*;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 128;

    logic              clk_133M = 1'b0;
    logic              rst_133M;
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] ddr_address;
    logic [DATA_W-1:0] ddr_wr_data;
    logic              cmd_busy;
    logic [DATA_W-1:0] ddr_rd_data;
    logic              ddr_data_valid;
    logic              init_done;
    logic              cmd_err;
    logic              mc_init_start;
    logic              mc_init_done;
    logic [3:0]        mc_cmd;
    logic              mc_cmd_valid;
    logic [ADDR_W-1:0] mc_addr;
    logic              mc_cmd_rdy;
    logic              mc_datain_rdy;
    logic [DATA_W-1:0] mc_write_data;
    logic [DATA_W-1:0] mc_read_data;
    logic              mc_read_data_valid;
    logic              rd_timeout;

    ddr_cmd_engine dut (
        .clk_133M          (clk_133M),
        .rst_133M          (rst_133M),
        .cmd               (cmd),
        .cmd_valid         (cmd_valid),
        .ddr_address       (ddr_address),
        .ddr_wr_data       (ddr_wr_data),
        .cmd_busy          (cmd_busy),
        .ddr_rd_data       (ddr_rd_data),
        .ddr_data_valid    (ddr_data_valid),
        .init_done         (init_done),
        .cmd_err           (cmd_err),
        .mc_init_start     (mc_init_start),
        .mc_init_done      (mc_init_done),
        .mc_cmd            (mc_cmd),
        .mc_cmd_valid      (mc_cmd_valid),
        .mc_addr           (mc_addr),
        .mc_cmd_rdy        (mc_cmd_rdy),
        .mc_datain_rdy     (mc_datain_rdy),
        .mc_write_data     (mc_write_data),
        .mc_read_data      (mc_read_data),
        .mc_read_data_valid(mc_read_data_valid),
        .rd_timeout        (rd_timeout)
    );

    // Clock / reset
    always #4 clk_133M = ~clk_133M;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                rdy_dly;
        int                din_dly;
        int                ret_dly;
        logic [DATA_W-1:0] rdata;
        bit                exp_issue;
        bit                exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs sampled there too.
    task automatic tick;
        @(posedge clk_133M);
        #1;
    endtask

    task automatic check_reset_vals;
        check("rst_busy", cmd_busy, 1'b1);
        check("rst_init_done", init_done, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        check("rst_mc_cmd_valid", mc_cmd_valid, 1'b0);
        check("rst_mc_init_start", mc_init_start, 1'b0);
        check("rst_data_valid", ddr_data_valid, 1'b0);
        check("rst_mc_write_data", mc_write_data, '0);
        check("rst_mc_addr", mc_addr, '0);
        check("rst_mc_cmd", mc_cmd, 4'd0);
        check("rst_rd_data", ddr_rd_data, '0);
        check("rst_rd_timeout", rd_timeout, 1'b0);
    endtask

    task automatic reset_and_init;
        rst_133M = 1'b1;
        repeat (2) tick();
        check_reset_vals();
        rst_133M = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("init_start", mc_init_start, (i >= 16) ? 1'b1 : 1'b0);
        end
        check("init_busy_pre", cmd_busy, 1'b1);
        mc_init_done = 1'b1;
        tick();
        mc_init_done = 1'b0;
        check("init_done", init_done, 1'b1);
        check("init_busy", cmd_busy, 1'b0);
        check("init_start_off", mc_init_start, 1'b0);
    endtask

    task automatic send_cmd(input logic [3:0] c, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        cmd = c; ddr_address = a; ddr_wr_data = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_vec(input vec_t v);
        send_cmd(v.cmd, v.addr, v.wdata);
        if (v.exp_issue) begin
            check("vec_mc_cmd_valid", mc_cmd_valid, 1'b1);
            check("vec_mc_cmd", mc_cmd, v.cmd);
            check("vec_mc_addr", mc_addr, v.addr);
            check("vec_busy_issue", cmd_busy, 1'b1);
            for (int i = 0; i < v.rdy_dly; i++) begin
                tick();
                check("vec_cmd_valid_held", mc_cmd_valid, 1'b1);
            end
            mc_cmd_rdy = 1'b1;
            tick();
            mc_cmd_rdy = 1'b0;
            check("vec_cmd_valid_drop", mc_cmd_valid, 1'b0);
            if (v.cmd == CMD_WR) begin
                check("vec_wr_data", mc_write_data, v.wdata);
                for (int i = 0; i < v.din_dly; i++) begin
                    check("vec_wr_busy", cmd_busy, 1'b1);
                    tick();
                end
                check("vec_wr_data_held", mc_write_data, v.wdata);
                mc_datain_rdy = 1'b1;
                tick();
                mc_datain_rdy = 1'b0;
                check("vec_wr_done_busy", cmd_busy, 1'b0);
            end else begin
                check("vec_rd_busy", cmd_busy, 1'b0);
                repeat (v.ret_dly) tick();
                mc_read_data = v.rdata; mc_read_data_valid = 1'b1;
                tick();
                mc_read_data_valid = 1'b0;
                check("vec_rd_valid", ddr_data_valid, 1'b1);
                check("vec_rd_data", ddr_rd_data, v.rdata);
                tick();
                check("vec_rd_valid_pulse", ddr_data_valid, 1'b0);
            end
        end else begin
            check("vec_no_issue", mc_cmd_valid, 1'b0);
            check("vec_no_issue_busy", cmd_busy, 1'b0);
        end
        check("vec_cmd_err", cmd_err, v.exp_err);
    endtask

    initial begin
        logic [DATA_W-1:0] rd_pat[4];
        bit seen;

        rst_133M = 1'b1;
        cmd = 4'd0; cmd_valid = 1'b0; ddr_address = '0; ddr_wr_data = '0;
        mc_init_done = 1'b0; mc_cmd_rdy = 1'b0; mc_datain_rdy = 1'b0;
        mc_read_data = '0; mc_read_data_valid = 1'b0;

        vecs[0] = '{CMD_WR, 25'h0001234, {16{8'hA5}}, 2, 3, 0, '0, 1'b1, 1'b0};
        vecs[1] = '{CMD_RD, 25'h1ABCDEF, '0, 0, 0, 2,
                    128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, 1'b0};
        vecs[2] = '{CMD_WR, 25'h1FFFFFF, {DATA_W{1'b1}}, 0, 0, 0, '0, 1'b1, 1'b0};
        vecs[3] = '{CMD_RD, 25'h0000000, '0, 1, 0, 0, {4{32'hDEADBEEF}}, 1'b1, 1'b0};
        vecs[4] = '{4'b0111, 25'h0000042, '0, 0, 0, 0, '0, 1'b0, 1'b1};
        vecs[5] = '{CMD_RD, 25'h0055AA5, '0, 0, 0, 1, {8{16'h5A3C}}, 1'b1, 1'b1};
        rd_pat[0] = {4{32'h11111111}};
        rd_pat[1] = {4{32'h22222222}};
        rd_pat[2] = {4{32'h33333333}};
        rd_pat[3] = {4{32'h44444444}};

        reset_and_init();
        foreach (vecs[i]) do_vec(vecs[i]);

        // Four back-to-back reads with no return: busy only after the fourth.
        reset_and_init();
        mc_cmd_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_cmd(CMD_RD, ADDR_W'(k), '0);
            tick();
            check("b2b_busy", cmd_busy, (k == 3) ? 1'b1 : 1'b0);
        end
        mc_cmd_rdy = 1'b0;
        repeat (5) tick();
        check("full_busy_held", cmd_busy, 1'b1);
        for (int k = 0; k < 4; k++) begin
            mc_read_data = rd_pat[k]; mc_read_data_valid = 1'b1;
            tick();
            check("ret_valid", ddr_data_valid, 1'b1);
            check("ret_data", ddr_rd_data, rd_pat[k]);
            check("ret_busy", cmd_busy, 1'b0);
        end
        mc_read_data_valid = 1'b0;
        tick();
        check("ret_valid_end", ddr_data_valid, 1'b0);
        check("ret_err_clean", cmd_err, 1'b0);

        // Return with nothing outstanding is dropped and flagged.
        mc_read_data = {DATA_W{1'b1}}; mc_read_data_valid = 1'b1;
        tick();
        mc_read_data_valid = 1'b0;
        check("uflow_valid", ddr_data_valid, 1'b0);
        check("uflow_err", cmd_err, 1'b1);

        // One read left outstanding, then a write aborted by reset in WR_DATA.
        mc_cmd_rdy = 1'b1;
        send_cmd(CMD_RD, 25'h0000100, '0);
        tick();
        send_cmd(CMD_WR, 25'h0000200, {8{16'hBEEF}});
        tick();
        mc_cmd_rdy = 1'b0;
        check("midwr_data", mc_write_data, {8{16'hBEEF}});
        check("midwr_busy", cmd_busy, 1'b1);
        rst_133M = 1'b1;
        tick();
        check_reset_vals();
        reset_and_init();

        // cmd_valid while in ISSUE is dropped; the held command is unchanged.
        send_cmd(CMD_RD, 25'h0000ABC, '0);
        send_cmd(CMD_WR, 25'h0000DEF, {DATA_W{1'b1}});
        check("issue_drop_valid", mc_cmd_valid, 1'b1);
        check("issue_drop_cmd", mc_cmd, CMD_RD);
        check("issue_drop_addr", mc_addr, 25'h0000ABC);
        check("issue_drop_err", cmd_err, 1'b1);
        mc_cmd_rdy = 1'b1;
        tick();
        check("issue_drop_no_wr", mc_cmd_valid, 1'b0);
        check("issue_drop_idle", cmd_busy, 1'b0);

        // Outstanding count restarted at 0 after reset: three more reads fill it.
        for (int k = 0; k < 3; k++) begin
            send_cmd(CMD_RD, ADDR_W'(k + 16), '0);
            tick();
            check("post_rst_busy", cmd_busy, (k == 2) ? 1'b1 : 1'b0);
        end
        mc_cmd_rdy = 1'b0;

        // Stalled reads: watchdog return with EN, otherwise busy holds forever.
        seen = 1'b0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            tick();
            if (ddr_data_valid) seen = 1'b1;
        end
`ifdef DDR_RD_TIMEOUT_EN
        check("wd_valid", seen, 1'b1);
        check("wd_data", ddr_rd_data, '0);
        check("wd_flag", rd_timeout, 1'b1);
`else
        check("no_wd_valid", seen, 1'b0);
        check("no_wd_flag", rd_timeout, 1'b0);
        check("no_wd_busy", cmd_busy, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
